muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle controller for the RV32M multiply/divide ops, which the single-cycle ALU cannot execute.
//  - Sequences an iterative radix-2 engine: shift-add for multiply, restoring division for divide.
//  - Sits beside the ALU in the execute stage. The ALU result mux takes Result when an M-op completes.
//  - Stall holds the PC and pipeline registers until done.
// PARAMETERS
//  DATA_WIDTH   32   operand/result width; iteration count equals DATA_WIDTH
// PORTS
//  clk        in   1            single clock, all state on rising edge
//  reset      in   1            synchronous, active-high
//  start      in   1            request pulse; sampled only in IDLE
//  flush      in   1            synchronous abort of current op (branch/jump squash)
//  Funct3     in   3            000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  SrcA       in   DATA_WIDTH   rs1 operand, captured at accepted start
//  SrcB       in   DATA_WIDTH   rs2 operand, captured at accepted start
//  busy       out  1            high in CALC and FINISH
//  Stall      out  1            busy | (start & IDLE & ~flush): combinational, stalls fetch same cycle
//  done       out  1            one-cycle pulse, Result valid
//  Result     out  DATA_WIDTH   final value, held until next accepted start
// BEHAVIOUR
//  Reset
//  - All outputs 0, FSM=IDLE, operand/accumulator regs 0. Reset overrides every other input.
//  - Reset mid-operation discards the op; no done is issued.
//  FSM: IDLE -> CALC -> FINISH -> IDLE
//  - IDLE: on start & ~flush, latch Funct3/SrcA/SrcB, go to CALC with cnt=0.
//    Signed ops (MULH, DIV, REM) and the signed rs1 of MULHSU latch magnitudes and record sign flags.
//  - CALC, multiply: per cycle, if multiplier LSB=1 add multiplicand to the upper half of the 2*W
//    accumulator; then shift right 1.
//  - CALC, divide: per cycle, shift {rem,quo} left 1; trial-subtract divisor; if no borrow keep the
//    difference and set quo LSB.
//  - CALC exit: after W cycles (cnt==W-1), go to FINISH.
//  - Divide special cases skip CALC (IDLE -> FINISH directly):
//    - divisor==0: quotient=all-ones, remainder=dividend.
//    - signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV/REM): quotient=0x80000000, remainder=0.
//  - FINISH: apply sign correction (2's-complement negate).
//    - product negated if signs differ.
//    - quotient negated if signs differ; remainder takes dividend sign.
//    - Result selection: MUL=low W bits; MULH/MULHSU/MULHU=high W bits; DIV/DIVU=quotient; REM/REMU=remainder.
//    - Register Result, pulse done=1 for one cycle, go to IDLE.
//  Latency
//  - Normal op: start accepted at edge N; done=1 during cycle N+W+1 (W CALC cycles + 1 FINISH).
//  - Special case: done during cycle N+1.
//  Handshake
//  - start while busy is ignored; no queueing.
//  - start in the done cycle is ignored; FSM is still in FINISH.
//  - start in the first IDLE cycle after done is accepted (back-to-back every W+2 cycles).
//  Flush
//  - In CALC or FINISH: next state IDLE, done stays 0, Result keeps its previous value.
//  - flush with start in IDLE: flush wins, nothing accepted.
//  Arithmetic
//  - All adds/subtracts W+1 bits wide, carry/borrow from the MSB.
//  - cnt is $clog2(W) bits; it wraps only via the IDLE reload, never free-runs.
// TESTING
//  1 MUL 7*6 -> done exactly 33 cycles after start edge, Result=42; busy high 33 cycles.
//  2 MULH 0xFFFFFFFF*0xFFFFFFFF (-1*-1) -> Result=0; MULHU same operands -> 0xFFFFFFFE.
//  3 DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14.
//  4 DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, both done 1 cycle after start.
//    DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
//  5 flush at CALC cycle 10 -> no done, busy low next cycle, Result unchanged.
//    Also: start during busy ignored; reset at cycle 20 -> all outputs 0.
//  6 back-to-back MUL 3*3 then DIVU 9/3 (second start in cycle after done) -> 9 then 3, each W+2 apart.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply/divide sequencer for the RV32M ops.
// Shift-add multiply, restoring divide, sign fix-up in FINISH.
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  flush,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  busy,
  output logic                  Stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    opb_q, opb_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [W-1:0]    res_q, res_d;

  logic            sgn_a, sgn_b;
  logic            neg_a, neg_b;
  logic [W-1:0]    mag_a, mag_b;
  logic            div_zero, div_ovf;
  logic [W:0]      add_sum, sum_hi, trial;
  logic [2*W-1:0]  mul_nxt, div_nxt;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    quo, rem, fin_val;

  assign sgn_a = (Funct3 == 3'b001) | (Funct3 == 3'b010) |
                 (Funct3 == 3'b100) | (Funct3 == 3'b110);
  assign sgn_b = (Funct3 == 3'b001) | (Funct3 == 3'b100) |
                 (Funct3 == 3'b110);
  assign neg_a = sgn_a & SrcA[W-1];
  assign neg_b = sgn_b & SrcB[W-1];
  assign mag_a = neg_a ? -SrcA : SrcA;
  assign mag_b = neg_b ? -SrcB : SrcB;

  assign div_zero = (SrcB == '0);
  assign div_ovf  = ~Funct3[0] & (SrcA == MIN_NEG) & (SrcB == '1);

  // multiply: acc = {partial product, remaining multiplier bits}
  assign add_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, opb_q};
  assign sum_hi  = acc_q[0] ? add_sum : {1'b0, acc_q[2*W-1:W]};
  assign mul_nxt = {sum_hi, acc_q[W-1:1]};

  // divide: trial uses the bit shifted out of rem as its carry-in MSB
  assign trial   = acc_q[2*W-1:W-1] - {1'b0, opb_q};
  assign div_nxt = trial[W] ? {acc_q[2*W-2:0], 1'b0}
                            : {trial[W-1:0], acc_q[W-2:0], 1'b1};

  assign prod = negq_q ? -acc_q : acc_q;
  assign quo  = negq_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign rem  = negr_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

  always_comb begin
    fin_val = rem;
    unique case (op_q)
      3'b000:                 fin_val = prod[W-1:0];
      3'b001, 3'b010, 3'b011: fin_val = prod[2*W-1:W];
      3'b100, 3'b101:         fin_val = quo;
      3'b110, 3'b111:         fin_val = rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d    = Funct3;
          cnt_d   = '0;
          negq_d  = neg_a ^ neg_b;
          negr_d  = neg_a;
          state_d = CALC;
          if (Funct3[2]) begin
            acc_d = {{W{1'b0}}, mag_a};
            opb_d = mag_b;
            if (div_zero) begin
              acc_d   = {SrcA, {W{1'b1}}};
              negq_d  = 1'b0;
              negr_d  = 1'b0;
              state_d = FINISH;
            end else if (div_ovf) begin
              acc_d   = {{W{1'b0}}, MIN_NEG};
              negq_d  = 1'b0;
              negr_d  = 1'b0;
              state_d = FINISH;
            end
          end else begin
            acc_d = {{W{1'b0}}, mag_b};
            opb_d = mag_a;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = op_q[2] ? div_nxt : mul_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
        if (!flush) res_d = fin_val;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      res_q   <= res_d;
    end
  end

  // done and Result are visible in the FINISH cycle so a flush can veto them
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == FINISH) & ~flush & ~reset;
  assign Result = done ? fin_val : res_q;
  assign Stall  = busy | (start & (state_q == IDLE) & ~flush);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer.
// Hand-computed vectors, immediate assertions, one summary line.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  Funct3;
  logic [31:0] SrcA, SrcB;
  logic        busy, Stall, done;
  logic [31:0] Result;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int busyc    = 0;
  int done_cyc = 0;
  int prev_cyc = 0;
  int lat;
  logic [31:0] r;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010;
  localparam logic [2:0] MULHU = 3'b011, DIV = 3'b100, DIVU = 3'b101;
  localparam logic [2:0] REM = 3'b110, REMU = 3'b111;

  muldiv_sequencer #(.DATA_WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .Funct3 (Funct3),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .busy   (busy),
    .Stall  (Stall),
    .done   (done),
    .Result (Result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sample index 1 is the first cycle after the accepting edge
  task automatic wait_done(input int first, output int l,
                           output logic [31:0] res);
    l   = 0;
    res = '0;
    for (int i = first; i <= first + 60; i++) begin
      if (busy) busyc++;
      if (done) begin
        l        = i;
        res      = Result;
        done_cyc = cyc;
        break;
      end
      step();
    end
  endtask

  task automatic launch(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b);
    Funct3 = f;
    SrcA   = a;
    SrcB   = b;
    start  = 1'b1;
    step();
    start  = 1'b0;
    busyc  = 0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat);
    int l;
    logic [31:0] res;
    Funct3 = f;
    SrcA   = a;
    SrcB   = b;
    start  = 1'b1;
    #1;
    chk({tag, " stall"}, {31'd0, Stall}, 32'd1);
    launch(f, a, b);
    wait_done(1, l, res);
    chk({tag, " lat"}, l, exp_lat);
    chk({tag, " res"}, res, exp_res);
    step();
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    Funct3 = '0;
    SrcA   = '0;
    SrcB   = '0;
    step();
    step();
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst stall", {31'd0, Stall}, 32'd0);
    chk("rst result", Result, 32'd0);
    reset = 1'b0;
    step();

    run_op("mul 7*6", MUL, 32'd7, 32'd6, 32'd42, 33);
    chk("mul busy cycles", busyc, 33);
    chk("mul held", Result, 32'd42);

    run_op("mulh -1*-1", MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 33);
    run_op("mulhu", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulhsu -1*2", MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33);
    run_op("mul -3*5", MUL, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 33);

    run_op("div -7/2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_op("rem -7/2", REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_op("rem 7/-2", REM, 32'd7, 32'hFFFFFFFE, 32'd1, 33);
    run_op("divu big", DIVU, 32'hFFFFFFFF, 32'h80000001, 32'd1, 33);
    run_op("remu big", REMU, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 33);

    run_op("div 5/0", DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op("remu 5/0", REMU, 32'd5, 32'd0, 32'd5, 1);
    run_op("rem -7/0", REM, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1);
    run_op("rem ovf", REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    run_op("div ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);

    // start together with flush in IDLE is dropped
    Funct3 = MUL;
    start  = 1'b1;
    flush  = 1'b1;
    #1;
    chk("idle flush stall", {31'd0, Stall}, 32'd0);
    step();
    start = 1'b0;
    flush = 1'b0;
    chk("idle flush busy", {31'd0, busy}, 32'd0);

    // flush in CALC cycle 10
    launch(MUL, 32'd7, 32'd6);
    for (int i = 1; i < 10; i++) step();
    chk("flush pre busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    #1;
    chk("flush done", {31'd0, done}, 32'd0);
    step();
    flush = 1'b0;
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush result", Result, 32'h80000000);
    step();
    chk("flush no done", {31'd0, done}, 32'd0);

    // start while busy is ignored, operands already captured
    launch(DIVU, 32'd100, 32'd7);
    step();
    step();
    Funct3 = MUL;
    SrcA   = 32'd3;
    SrcB   = 32'd3;
    start  = 1'b1;
    step();
    start  = 1'b0;
    wait_done(4, lat, r);
    chk("busy start lat", lat, 33);
    chk("busy start res", r, 32'd14);

    // start in the done cycle is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    chk("done start busy", {31'd0, busy}, 32'd0);
    step();
    chk("done start idle", {31'd0, busy}, 32'd0);
    chk("done start held", Result, 32'd14);

    // reset mid-operation
    launch(MUL, 32'd7, 32'd6);
    for (int i = 1; i < 20; i++) step();
    reset = 1'b1;
    step();
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst stall", {31'd0, Stall}, 32'd0);
    chk("midrst result", Result, 32'd0);
    reset = 1'b0;
    step();
    chk("midrst no done", {31'd0, done}, 32'd0);

    // back-to-back ops
    run_op("b2b mul 3*3", MUL, 32'd3, 32'd3, 32'd9, 33);
    prev_cyc = done_cyc;
    run_op("b2b divu 9/3", DIVU, 32'd9, 32'd3, 32'd3, 33);
    chk("b2b spacing", done_cyc - prev_cyc, 34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
